mem_access_stage: RTL and testbench

//  Memory-access (MEM) stage of the LEGv8 pipeline; consumes execute-stage results (alu_result, zero, branch_target).

---
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage -- LEGv8 pipeline memory-access (MEM) stage.
//
// Accepts one execute-stage result per cycle at the EX/MEM boundary, runs
// LDUR/STUR on the data-memory req/ack bus, resolves branches toward fetch
// and presents a registered result to writeback. ex_ready is low while a
// memory access is outstanding, so upstream holds its result.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   ex_valid / ex_ready             EX handshake (ready only in IDLE)
//   ex_alu_result, ex_zero          ALU result (also memory address), zero flag
//   ex_branch_tgt, ex_store_data    branch target, STUR write data
//   ex_mem_read/write, ex_branch,
//   ex_uncond, ex_reg_write,
//   ex_mem_to_reg, ex_rd            control bits and destination register
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_rdata, dm_ack      data-memory request/acknowledge bus
//   pc_src, pc_branch_tgt           one-cycle taken-branch pulse and target
//   wb_valid, wb_data, wb_rd,
//   wb_reg_write                    writeback result (wb_valid is a pulse)
//   misalign_fault                  one-cycle pulse on a misaligned mem op
//
// Build option: MEM_ALIGN_CHECK_EN enables the doubleword alignment check.
// Without it misalign_fault is constant 0 and addresses pass unmodified.
//
// state  | meaning
// IDLE   | ready for a new EX result
// ACCESS | memory request outstanding, waiting for dm_ack

module mem_access_stage #(
    parameter int WORD_W     = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [WORD_W-1:0]     ex_alu_result,
    input  logic                  ex_zero,
    input  logic [WORD_W-1:0]     ex_branch_tgt,
    input  logic [WORD_W-1:0]     ex_store_data,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_branch,
    input  logic                  ex_uncond,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [WORD_W-1:0]     dm_addr,
    output logic [WORD_W-1:0]     dm_wdata,
    input  logic [WORD_W-1:0]     dm_rdata,
    input  logic                  dm_ack,
    output logic                  pc_src,
    output logic [WORD_W-1:0]     pc_branch_tgt,
    output logic                  wb_valid,
    output logic [WORD_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write,
    output logic                  misalign_fault
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t state, state_next;

    logic                  accept;
    logic                  mem_op;
    logic                  misalign;
    logic                  start_mem;
    logic                  ack_done;
    logic                  taken;
    logic [WORD_W-1:0]     cap_alu;
    logic [REG_ADDR_W-1:0] cap_rd;
    logic                  cap_reg_write;
    logic                  cap_load_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        start_mem  = 1'b0;
        ack_done   = 1'b0;
        misalign   = 1'b0;
        ex_ready   = (state == S_IDLE);
        mem_op     = ex_mem_read | ex_mem_write;
        taken      = ex_uncond | (ex_branch & ex_zero);
`ifdef MEM_ALIGN_CHECK_EN
        misalign   = mem_op & (ex_alu_result[2:0] != 3'b000);
`endif
        case (state)
            S_IDLE: begin
                accept = ex_valid;
                if (ex_valid && mem_op && !misalign) begin
                    start_mem  = 1'b1;
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // dm_ack outside ACCESS (e.g. after a reset) is ignored
                if (dm_ack) begin
                    ack_done   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dm_req         <= 1'b0;
            dm_we          <= 1'b0;
            dm_addr        <= '0;
            dm_wdata       <= '0;
            pc_src         <= 1'b0;
            pc_branch_tgt  <= '0;
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_rd          <= '0;
            wb_reg_write   <= 1'b0;
            misalign_fault <= 1'b0;
            cap_alu        <= '0;
            cap_rd         <= '0;
            cap_reg_write  <= 1'b0;
            cap_load_sel   <= 1'b0;
        end else begin
            pc_src         <= 1'b0;
            wb_valid       <= 1'b0;
            misalign_fault <= 1'b0;
            if (accept) begin
                pc_src        <= taken;
                pc_branch_tgt <= ex_branch_tgt;
                cap_alu       <= ex_alu_result;
                cap_rd        <= ex_rd;
                cap_reg_write <= ex_reg_write & ~ex_mem_write;
                cap_load_sel  <= ex_mem_to_reg & ex_mem_read;
                if (start_mem) begin
                    dm_req   <= 1'b1;
                    dm_we    <= ex_mem_write;
                    dm_addr  <= ex_alu_result;
                    dm_wdata <= ex_store_data;
                end else begin
                    // plain ALU op, or a mem op rejected as misaligned
                    wb_valid       <= 1'b1;
                    wb_data        <= ex_alu_result;
                    wb_rd          <= ex_rd;
                    wb_reg_write   <= ex_reg_write & ~ex_mem_write & ~misalign;
                    misalign_fault <= misalign;
                end
            end
            if (ack_done) begin
                dm_req       <= 1'b0;
                dm_we        <= 1'b0;
                wb_valid     <= 1'b1;
                wb_data      <= cap_load_sel ? dm_rdata : cap_alu;
                wb_rd        <= cap_rd;
                wb_reg_write <= cap_reg_write;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_alu_result;
    logic        ex_zero;
    logic [63:0] ex_branch_tgt;
    logic [63:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_uncond;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic [4:0]  ex_rd;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;
    logic        dm_ack;
    logic        pc_src;
    logic [63:0] pc_branch_tgt;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.WORD_W(64), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
        .ex_branch_tgt(ex_branch_tgt), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_uncond(ex_uncond),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_rd(ex_rd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .pc_src(pc_src), .pc_branch_tgt(pc_branch_tgt),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .misalign_fault(misalign_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete EX operation. Expectations come from the stage's rules:
    // ALU ops and rejected mem ops write back one cycle after accept; mem ops
    // hold the request for (waits+1) cycles and write back one cycle after ack.
    task automatic run_op(input string tag,
                          input logic [63:0] alu, input logic [63:0] tgt,
                          input logic [63:0] sd,  input logic [63:0] rdata,
                          input logic is_ld, input logic is_st,
                          input logic br, input logic un, input logic zero,
                          input logic regw, input logic [4:0] rd, input int waits);
        logic taken, mis, mem;
        logic [63:0] exp_data;
        taken = un | (br & zero);
        mem   = is_ld | is_st;
        mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis   = mem && (alu % 8 != 0);
`endif
        @(negedge clk);
        ex_valid = 1'b1; ex_alu_result = alu; ex_branch_tgt = tgt;
        ex_store_data = sd; ex_mem_read = is_ld; ex_mem_write = is_st;
        ex_branch = br; ex_uncond = un; ex_zero = zero;
        ex_reg_write = regw; ex_mem_to_reg = is_ld; ex_rd = rd;
        chk({tag, ":ready_before"}, ex_ready, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk({tag, ":pc_src"}, pc_src, taken);
        if (taken) chk({tag, ":pc_tgt"}, pc_branch_tgt, tgt);
        if (!mem || mis) begin
            chk({tag, ":wb_valid"}, wb_valid, 1'b1);
            chk({tag, ":wb_data"}, wb_data, alu);
            chk({tag, ":wb_rd"}, wb_rd, rd);
            chk({tag, ":wb_rw"}, wb_reg_write, regw && !mem);
            chk({tag, ":fault"}, misalign_fault, mis);
            chk({tag, ":no_req"}, dm_req, 1'b0);
            chk({tag, ":ready"}, ex_ready, 1'b1);
        end else begin
            chk({tag, ":req"}, dm_req, 1'b1);
            chk({tag, ":we"}, dm_we, is_st);
            chk({tag, ":addr"}, dm_addr, alu);
            if (is_st) chk({tag, ":wdata"}, dm_wdata, sd);
            chk({tag, ":busy"}, ex_ready, 1'b0);
            chk({tag, ":no_wb"}, wb_valid, 1'b0);
            for (int i = 0; i < waits; i++) begin
                @(negedge clk);
                // upstream presents (and holds) the next op; it must not be taken
                ex_valid = 1'b1; ex_alu_result = alu ^ 64'hFFFF_0000;
                ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_uncond = 1'b1;
                tick();
                chk({tag, ":req_hold"}, dm_req, 1'b1);
                chk({tag, ":addr_hold"}, dm_addr, alu);
                chk({tag, ":we_hold"}, dm_we, is_st);
                chk({tag, ":wait_busy"}, ex_ready, 1'b0);
                chk({tag, ":wait_wb"}, wb_valid, 1'b0);
                chk({tag, ":wait_pc"}, pc_src, 1'b0);
            end
            @(negedge clk);
            ex_valid = 1'b0; dm_ack = 1'b1; dm_rdata = rdata;
            tick();
            dm_ack = 1'b0;
            exp_data = is_ld ? rdata : alu;
            chk({tag, ":ack_wb"}, wb_valid, 1'b1);
            chk({tag, ":ack_data"}, wb_data, exp_data);
            chk({tag, ":ack_rd"}, wb_rd, rd);
            chk({tag, ":ack_rw"}, wb_reg_write, regw && !is_st);
            chk({tag, ":ack_req"}, dm_req, 1'b0);
            chk({tag, ":ack_ready"}, ex_ready, 1'b1);
            chk({tag, ":ack_pc"}, pc_src, 1'b0);
        end
        tick();
        chk({tag, ":wb_pulse"}, wb_valid, 1'b0);
        chk({tag, ":pc_pulse"}, pc_src, 1'b0);
        chk({tag, ":fault_pulse"}, misalign_fault, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_zero = 1'b0;
        ex_branch_tgt = '0; ex_store_data = '0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_branch = 1'b0; ex_uncond = 1'b0;
        ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0; ex_rd = '0;
        dm_rdata = '0; dm_ack = 1'b0;
        tick(); tick();
        chk("rst:dm_req", dm_req, 1'b0);
        chk("rst:dm_we", dm_we, 1'b0);
        chk("rst:dm_addr", dm_addr, 64'h0);
        chk("rst:pc_src", pc_src, 1'b0);
        chk("rst:wb_valid", wb_valid, 1'b0);
        chk("rst:wb_data", wb_data, 64'h0);
        chk("rst:wb_rw", wb_reg_write, 1'b0);
        chk("rst:fault", misalign_fault, 1'b0);
        chk("rst:ready", ex_ready, 1'b1);
        @(negedge clk); rst_n = 1'b1;

        // directed cases
        run_op("add",    64'h2A,  64'h0,  64'h0,  64'h0,    0, 0, 0, 0, 0, 1, 5'd3, 0);
        run_op("ldur",   64'h100, 64'h0,  64'h0,  64'hDEAD, 1, 0, 0, 0, 0, 1, 5'd7, 2);
        run_op("stur",   64'h8,   64'h0,  64'h55, 64'h0,    0, 1, 0, 0, 0, 1, 5'd9, 0);
        run_op("cbz_t",  64'h0,   64'h40, 64'h0,  64'h0,    0, 0, 1, 0, 1, 0, 5'd0, 0);
        run_op("cbz_nt", 64'h5,   64'h40, 64'h0,  64'h0,    0, 0, 1, 0, 0, 0, 5'd0, 0);
        run_op("b",      64'h0,   64'h88, 64'h0,  64'h0,    0, 0, 0, 1, 0, 0, 5'd0, 0);
        run_op("ld_br",  64'h18,  64'h1C0, 64'h0, 64'h77,   1, 0, 0, 1, 0, 1, 5'd31, 1);

        // reset in the middle of an access, then a late ack
        @(negedge clk);
        ex_valid = 1'b1; ex_alu_result = 64'h200; ex_mem_read = 1'b1;
        ex_mem_write = 1'b0; ex_branch = 1'b0; ex_uncond = 1'b0;
        ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1; ex_rd = 5'd4;
        tick();
        ex_valid = 1'b0;
        chk("rstacc:req", dm_req, 1'b1);
        @(negedge clk); rst_n = 1'b0;
        tick();
        chk("rstacc:req_drop", dm_req, 1'b0);
        chk("rstacc:ready", ex_ready, 1'b1);
        @(negedge clk); rst_n = 1'b1; dm_ack = 1'b1; dm_rdata = 64'hBAD;
        tick();
        dm_ack = 1'b0;
        chk("rstacc:no_wb", wb_valid, 1'b0);
        chk("rstacc:no_req", dm_req, 1'b0);
        chk("rstacc:idle", ex_ready, 1'b1);
        tick();
        chk("rstacc:no_wb2", wb_valid, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
        run_op("misalign", 64'h104, 64'h0, 64'h0, 64'h0, 1, 0, 0, 0, 0, 1, 5'd6, 0);
`endif

        // randomized operations
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [63:0] a;
            kind = $urandom_range(0, 2);
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
            run_op("rnd", a, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, kind == 1, kind == 2,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
